// File: rtl/jtkunio_rom_arb2.sv
// Two-slot ROM fetch arbiter for one SDRAM bank: one-entry cache per slot, misses become
// single SDRAM reads, 16-bit controller words are reassembled into 8/16/32-bit slot data.

module jtkunio_rom_arb2_slot #(
  parameter int          AW     = 14,
  parameter int          DW     = 32,
  parameter logic [21:0] OFFSET = 22'h0,
  parameter int          CW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          start,
  input  logic          fill_we,
  input  logic [CW-1:0] fill_data,
  output logic [DW-1:0] dout,
  output logic          ok,
  output logic          pend,
  output logic [21:0]   map_addr
);
  // Byte slots cache a whole 16-bit word, so addr[0] is not part of the tag
  localparam int TW = (DW == 8) ? AW - 1 : AW;

  logic [TW-1:0] tag_q;
  logic [TW-1:0] ltag_q;
  logic [TW-1:0] cur_tag;
  logic          valid_q;
  logic          hit;
  logic [CW-1:0] data_q;

  assign cur_tag = addr[AW-1 -: TW];
  assign hit     = valid_q && (tag_q == cur_tag);
  assign ok      = cs & hit;
  assign pend    = cs & ~hit;

  generate
    if (DW == 8) begin : g_byte
      assign map_addr = OFFSET + 22'(addr[AW-1:1]);
      assign dout     = addr[0] ? data_q[15:8] : data_q[7:0];
    end else if (DW == 16) begin : g_half
      assign map_addr = OFFSET + 22'(addr);
      assign dout     = data_q;
    end else begin : g_word
      assign map_addr = OFFSET + 22'({addr, 1'b0});
      assign dout     = data_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      ltag_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (start) ltag_q <= cur_tag;
      if (fill_we) begin
        tag_q   <= ltag_q;
        valid_q <= 1'b1;
        data_q  <= fill_data;
      end
    end
  end
endmodule

module jtkunio_rom_arb2 #(
  parameter int          SLOT0_AW     = 14,
  parameter int          SLOT0_DW     = 32,
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter int          SLOT1_AW     = 17,
  parameter int          SLOT1_DW     = 32,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slot0_cs,
  input  logic                slot1_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [SLOT0_DW-1:0] slot0_dout,
  output logic [SLOT1_DW-1:0] slot1_dout,
  output logic                slot0_ok,
  output logic                slot1_ok,
  output logic [21:0]         sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);
  localparam int CW0 = (SLOT0_DW == 32) ? 32 : 16;
  localparam int CW1 = (SLOT1_DW == 32) ? 32 : 16;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t         state_q, state_d;
  logic           pend0, pend1, pick;
  logic           start0, start1, fill_done, fill_we0, fill_we1;
  logic           sel_q, last_q, wcnt_q;
  logic [15:0]    buf_q;
  logic [21:0]    addr_q, map0, map1;
  logic [CW0-1:0] fill0;
  logic [CW1-1:0] fill1;

  jtkunio_rom_arb2_slot #(
    .AW(SLOT0_AW), .DW(SLOT0_DW), .OFFSET(SLOT0_OFFSET), .CW(CW0)
  ) u_slot0 (
    .clk(clk), .rst_n(rst_n), .cs(slot0_cs), .addr(slot0_addr),
    .start(start0), .fill_we(fill_we0), .fill_data(fill0),
    .dout(slot0_dout), .ok(slot0_ok), .pend(pend0), .map_addr(map0)
  );

  jtkunio_rom_arb2_slot #(
    .AW(SLOT1_AW), .DW(SLOT1_DW), .OFFSET(SLOT1_OFFSET), .CW(CW1)
  ) u_slot1 (
    .clk(clk), .rst_n(rst_n), .cs(slot1_cs), .addr(slot1_addr),
    .start(start1), .fill_we(fill_we1), .fill_data(fill1),
    .dout(slot1_dout), .ok(slot1_ok), .pend(pend1), .map_addr(map1)
  );

  // On a tie the slot that did not complete the last fill goes first
  assign pick = (pend0 & pend1) ? ~last_q : pend1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pend0 | pend1)        state_d = WAIT_ACK;
      WAIT_ACK:  if (sdram_ack)            state_d = WAIT_DATA;
      WAIT_DATA: if (data_dst && data_rdy) state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = 1'b0;
    start0    = 1'b0;
    start1    = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        start0 = (pend0 | pend1) & ~pick;
        start1 = (pend0 | pend1) & pick;
      end
      WAIT_ACK:  sdram_req = 1'b1;
      WAIT_DATA: fill_done = data_dst & data_rdy;
      default: ;
    endcase
    fill_we0 = fill_done & ~sel_q;
    fill_we1 = fill_done & sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 1'b0;
      last_q <= 1'b1;
      wcnt_q <= 1'b0;
      buf_q  <= '0;
      addr_q <= '0;
    end else begin
      if (start0 | start1) begin
        sel_q  <= pick;
        addr_q <= pick ? map1 : map0;
      end
      if (state_q == WAIT_ACK && sdram_ack) wcnt_q <= 1'b0;
      if (state_q == WAIT_DATA && data_dst) begin
        if (!wcnt_q) buf_q <= data_read;
        wcnt_q <= 1'b1;
      end
      if (fill_done) last_q <= sel_q;
    end
  end

  // The final word is taken straight off the bus since it coincides with data_rdy
  generate
    if (CW0 == 32) begin : g_fill0_w
      assign fill0 = {data_read, buf_q};
    end else begin : g_fill0_h
      assign fill0 = wcnt_q ? buf_q : data_read;
    end
    if (CW1 == 32) begin : g_fill1_w
      assign fill1 = {data_read, buf_q};
    end else begin : g_fill1_h
      assign fill1 = wcnt_q ? buf_q : data_read;
    end
  endgenerate

  assign sdram_addr = addr_q;
endmodule
